// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, RGB444 pixel type and scanout latency shared
// by the display blocks in the video clock domain.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_FB_WIDTH    = 320;
  localparam int VGA_SCALE_SHIFT = 1;
  localparam int VGA_ADDR_W      = 17;

  // Clocks from stage-0 counter state to the VGA pins.
  localparam int SCANOUT_LAT = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with active-low syncs, active window,
// frame_start pulse and vblank, all in stage-0 (undelayed) timing.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           reset,
  output logic [H_W-1:0] h_o,
  output logic [V_W-1:0] v_o,
  output logic           active_o,
  output logic           hs_n_o,
  output logic           vs_n_o,
  output logic           line_end_o,
  output logic           frame_end_o,
  output logic           frame_start_o,
  output logic           vblank_o
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  assign line_end_o  = (h_q == H_W'(H_TOTAL - 1));
  assign frame_end_o = line_end_o && (v_q == V_W'(V_TOTAL - 1));

  always_comb begin
    h_d = h_q + H_W'(1);
    v_d = v_q;
    if (line_end_o) begin
      h_d = '0;
      v_d = frame_end_o ? '0 : v_q + V_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign active_o = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
  assign hs_n_o   = !((h_q >= H_W'(HS_START)) && (h_q < H_W'(HS_END)));
  assign vs_n_o   = !((v_q >= V_W'(VS_START)) && (v_q < V_W'(VS_END)));

  // Counters already sit at 0,0 while reset is held; gating keeps the
  // pulse from firing until the first running cycle.
  assign frame_start_o = !reset && (h_q == '0) && (v_q == '0);
  assign vblank_o      = !reset && (v_q >= V_W'(V_ACTIVE));

endmodule

// File: rtl/vga_scanout.sv
// Streams a pixel-doubled frame buffer from VRAM to the VGA DAC pins, with
// syncs delayed to match the address -> data -> output register pipeline.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int FB_WIDTH    = VGA_FB_WIDTH,
  parameter int SCALE_SHIFT = VGA_SCALE_SHIFT,
  parameter int ADDR_W      = VGA_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [11:0]       vram_data,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start,
  output logic              vblank
);

  localparam int H_W       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int V_W       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int LAST_ADDR = (V_ACTIVE >> SCALE_SHIFT) * FB_WIDTH - 1;
  localparam logic [V_W-1:0] SCALE_MASK = V_W'((1 << SCALE_SHIFT) - 1);

  if ((H_ACTIVE >> SCALE_SHIFT) != FB_WIDTH) begin : g_bad_fb_width
    $error("vga_scanout: H_ACTIVE >> SCALE_SHIFT must equal FB_WIDTH");
  end
  if (LAST_ADDR >= (1 << ADDR_W)) begin : g_bad_addr_w
    $error("vga_scanout: ADDR_W too small for the frame buffer");
  end

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           active, hs_n, vs_n, line_end, frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .h_o          (h),
    .v_o          (v),
    .active_o     (active),
    .hs_n_o       (hs_n),
    .vs_n_o       (vs_n),
    .line_end_o   (line_end),
    .frame_end_o  (frame_end),
    .frame_start_o(frame_start),
    .vblank_o     (vblank)
  );

  // VRAM port is a fixed-latency request with no backpressure: data for the
  // address presented with vram_rd high is valid on vram_data one clk later.
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, active_d2_q;
  rgb444_t           rgb_q, rgb_d;
  logic [SCANOUT_LAT-1:0] hs_pipe_q, vs_pipe_q;
  logic [V_W-1:0]    v_next;
  logic              row_step;

  // Row base advances once per replicated source row, at the end of the
  // line preceding its first display line.
  assign v_next   = v + V_W'(1);
  assign row_step = (v_next < V_W'(V_ACTIVE)) && ((v_next & SCALE_MASK) == '0);

  always_comb begin
    row_base_d = row_base_q;
    if (frame_end) begin
      row_base_d = '0;
    end else if (line_end && row_step) begin
      row_base_d = row_base_q + ADDR_W'(FB_WIDTH);
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (active) begin
      addr_d = row_base_q + ADDR_W'(h >> SCALE_SHIFT);
    end
    rgb_d = active_d2_q ? rgb444_t'(vram_data) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_base_q  <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      active_d2_q <= 1'b0;
      rgb_q       <= '0;
      hs_pipe_q   <= '1;
      vs_pipe_q   <= '1;
    end else begin
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      rd_q        <= active;
      active_d2_q <= rd_q;
      rgb_q       <= rgb_d;
      hs_pipe_q   <= {hs_pipe_q[SCANOUT_LAT-2:0], hs_n};
      vs_pipe_q   <= {vs_pipe_q[SCANOUT_LAT-2:0], vs_n};
    end
  end

  assign vram_addr = addr_q;
  assign vram_rd   = rd_q;
  assign vga_hs    = hs_pipe_q[SCANOUT_LAT-1];
  assign vga_vs    = vs_pipe_q[SCANOUT_LAT-1];
  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;

endmodule
